// File: rtl/pb_press_ctrl.sv
// -----------------------------------------------------------------------------
// pb_press_ctrl
//
// Purpose:
//   Consumes the debounced push-button level (pb_s_de) in the clk_f domain.
//   It turns the level into single-cycle event pulses and classifies each press
//   as short or long. It also owns the run/pause bit of the stopwatch datapath:
//   a short press toggles run, and a long press forces run to 0 and requests a
//   clear.
//
// Parameters:
//   LONG_CNT  consecutive high samples that make a long press (>= 2)
//   CNT_W     hold-counter width; 2**CNT_W must exceed LONG_CNT
//
// Ports:
//   clk_f        in   1  slow system clock; all logic runs on its posedge
//   rst          in   1  asynchronous, active-high reset
//   pb_s_de      in   1  debounced button level, synchronous to clk_f (1 = pressed)
//   pb_pulse     out  1  1-cycle pulse on each press (rising edge of pb_s_de)
//   short_press  out  1  1-cycle pulse on release after 1..LONG_CNT-1 high samples
//   long_press   out  1  1-cycle pulse on the LONG_CNT-th consecutive high sample
//   clr          out  1  1-cycle clear request, coincident with long_press
//   run          out  1  run(1)/pause(0) level
//   state_o      out  2  current FSM state (IDLE=0, PRESSED=1, HELD=2)
//
// Every output is a register.
// -----------------------------------------------------------------------------
module pb_press_ctrl #(
    parameter int LONG_CNT = 100,
    parameter int CNT_W    = 7
) (
    input  logic       clk_f,
    input  logic       rst,
    input  logic       pb_s_de,
    output logic       pb_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       clr,
    output logic       run,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2,
        BAD     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LONG_CNT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Resets to 1 so that a button already held across reset does not count
    // as a press. It must be released first.
    logic             pb_prev;

    logic             pb_pulse_next;
    logic             short_press_next;
    logic             long_press_next;
    logic             clr_next;
    logic             run_next;

    // State and output registers.
    always_ff @(posedge clk_f or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= CNT_ZERO;
            pb_prev     <= 1'b1;
            pb_pulse    <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            clr         <= 1'b0;
            run         <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pb_prev     <= pb_s_de;
            pb_pulse    <= pb_pulse_next;
            short_press <= short_press_next;
            long_press  <= long_press_next;
            clr         <= clr_next;
            run         <= run_next;
        end
    end

    // Next-state and next-output logic. Pulses default low, so each one is
    // high for exactly one cycle. run holds unless a press classification
    // changes it.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        pb_pulse_next    = 1'b0;
        short_press_next = 1'b0;
        long_press_next  = 1'b0;
        clr_next         = 1'b0;
        run_next         = run;

        case (state)
            IDLE: begin
                if (pb_s_de && !pb_prev) begin
                    state_next    = PRESSED;
                    cnt_next      = CNT_ONE;
                    pb_pulse_next = 1'b1;
                end else begin
                    cnt_next = CNT_ZERO;
                end
            end

            PRESSED: begin
                if (pb_s_de) begin
                    if (cnt == CNT_LAST) begin
                        // This sample is the LONG_CNT-th high one.
                        state_next      = HELD;
                        cnt_next        = CNT_FULL;
                        long_press_next = 1'b1;
                        clr_next        = 1'b1;
                        run_next        = 1'b0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else begin
                    state_next       = IDLE;
                    cnt_next         = CNT_ZERO;
                    short_press_next = 1'b1;
                    run_next         = ~run;
                end
            end

            HELD: begin
                // The press is already classified. Wait for release quietly,
                // with the counter pinned at LONG_CNT.
                if (pb_s_de) begin
                    cnt_next = CNT_FULL;
                end else begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end
            end

            default: begin
                // The unused encoding recovers to IDLE.
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_pb_press_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pb_press_ctrl
//
// Purpose:
//   Directed self-checking bench for pb_press_ctrl with LONG_CNT=4. Each step
//   drives one pb_s_de sample and pushes the expected output vector
//   {pb_pulse, short_press, long_press, clr, run, state_o} onto a queue. That
//   vector is popped and compared just after the clock edge that consumes the
//   sample.
// -----------------------------------------------------------------------------
module tb_pb_press_ctrl;

    localparam int LONG_CNT = 4;
    localparam int CNT_W    = 3;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk_f;
    logic       rst;
    logic       pb_s_de;
    logic       pb_pulse;
    logic       short_press;
    logic       long_press;
    logic       clr;
    logic       run;
    logic [1:0] state_o;

    initial begin
        clk_f = 1'b0;
        forever #5 clk_f = ~clk_f;
    end

    pb_press_ctrl #(
        .LONG_CNT (LONG_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_f       (clk_f),
        .rst         (rst),
        .pb_s_de     (pb_s_de),
        .pb_pulse    (pb_pulse),
        .short_press (short_press),
        .long_press  (long_press),
        .clr         (clr),
        .run         (run),
        .state_o     (state_o)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [6:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [6:0] ev(input logic pp, input logic sp,
                                      input logic lp, input logic cl,
                                      input logic rn, input logic [1:0] st);
        return {pp, sp, lp, cl, rn, st};
    endfunction

    function automatic logic [6:0] observed();
        return {pb_pulse, short_press, long_press, clr, run, state_o};
    endfunction

    task automatic compare(input string tag);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = observed();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard queue empty, observed=%b", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed={pp,sp,lp,clr,run,st}=%b expected=%b",
                       tag, obs, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks. Each is entered 1 time unit after a posedge.
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic [6:0] exp, input string tag);
        pb_s_de = v;
        exp_q.push_back(exp);
        @(posedge clk_f);
        #1;
        compare(tag);
    endtask

    // Compares against the expected vector without consuming a sample.
    task automatic check_now(input logic [6:0] exp, input string tag);
        exp_q.push_back(exp);
        compare(tag);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        pb_s_de = 1'b0;

        // 1. Reset held with the button low.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_f);
            #1;
            check_now(ev(0,0,0,0,0,2'd0), "reset_hold");
        end
        rst = 1'b0;
        step(0, ev(0,0,0,0,0,2'd0), "t1_idle_after_reset");

        // 2. Two high samples: a short press that sets run.
        step(1, ev(1,0,0,0,0,2'd1), "t2_press_pulse");
        step(1, ev(0,0,0,0,0,2'd1), "t2_pressed_hold");
        step(0, ev(0,1,0,0,1,2'd0), "t2_short_release");
        step(0, ev(0,0,0,0,1,2'd0), "t2_idle_run_held");

        // 3. Six high samples from run=1: a long press, then a silent release.
        step(1, ev(1,0,0,0,1,2'd1), "t3_press_pulse");
        step(1, ev(0,0,0,0,1,2'd1), "t3_cnt2");
        step(1, ev(0,0,0,0,1,2'd1), "t3_cnt3");
        step(1, ev(0,0,1,1,0,2'd2), "t3_long_clr");
        step(1, ev(0,0,0,0,0,2'd2), "t3_held5");
        step(1, ev(0,0,0,0,0,2'd2), "t3_held6");
        step(0, ev(0,0,0,0,0,2'd0), "t3_release_silent");
        step(0, ev(0,0,0,0,0,2'd0), "t3_idle");

        // 4. Back-to-back 1-sample presses: run toggles twice.
        step(1, ev(1,0,0,0,0,2'd1), "t4_press_a");
        step(0, ev(0,1,0,0,1,2'd0), "t4_short_a");
        step(1, ev(1,0,0,0,1,2'd1), "t4_press_b");
        step(0, ev(0,1,0,0,0,2'd0), "t4_short_b");
        step(0, ev(0,0,0,0,0,2'd0), "t4_idle");

        // 6. LONG_CNT-1 high samples is still a short press.
        step(1, ev(1,0,0,0,0,2'd1), "t6_press");
        step(1, ev(0,0,0,0,0,2'd1), "t6_cnt2");
        step(1, ev(0,0,0,0,0,2'd1), "t6_cnt3");
        step(0, ev(0,1,0,0,1,2'd0), "t6_short_not_long");
        step(0, ev(0,0,0,0,1,2'd0), "t6_idle");

        // 5. Asynchronous reset mid-press (state 1, cnt 2, run 1).
        step(1, ev(1,0,0,0,1,2'd1), "t5_press");
        step(1, ev(0,0,0,0,1,2'd1), "t5_cnt2");
        #2;
        rst = 1'b1;
        #1;
        check_now(ev(0,0,0,0,0,2'd0), "t5_async_reset");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_f);
            #1;
            check_now(ev(0,0,0,0,0,2'd0), "t5_reset_hold");
        end
        rst = 1'b0;
        step(1, ev(0,0,0,0,0,2'd0), "t5_held_no_pulse_a");
        step(1, ev(0,0,0,0,0,2'd0), "t5_held_no_pulse_b");
        step(0, ev(0,0,0,0,0,2'd0), "t5_release");
        step(1, ev(1,0,0,0,0,2'd1), "t5_new_press");
        step(0, ev(0,1,0,0,1,2'd0), "t5_new_short");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain leftover=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
